// File: rtl/gray_pkg.sv
// Shared constants and types for the Gray-count receiver.
package gray_pkg;

    localparam int unsigned ERR_CODE_W = 2;
    localparam int unsigned ERR_CNT_W  = 8;

    localparam logic [ERR_CODE_W-1:0] ERR_NONE  = 2'b00;
    localparam logic [ERR_CODE_W-1:0] ERR_MULTI = 2'b01;
    localparam logic [ERR_CODE_W-1:0] ERR_BACK  = 2'b10;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/gry2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gry2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gry,
    output logic [WIDTH-1:0] o_bin_c
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [WIDTH-1:0] w_upper;
        assign w_upper    = i_gry >> i;
        assign o_bin_c[i] = ^w_upper;
    end

endmodule

// File: rtl/gray_cnt_rx.sv
// Synchronizes an incoming Gray count, decodes it and checks every change is a single forward step.
module gray_cnt_rx
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      gry_in,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      bin_cnt,
    output logic [WIDTH-1:0]      gry_q,
    output logic                  vld,
    output logic                  step,
    output logic                  err,
    output logic [ERR_CODE_W-1:0] err_code,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]      r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]      w_gry_s;
    logic [WIDTH-1:0]      w_bin_s;
    logic [WIDTH-1:0]      w_diff;
    logic                  w_one_bit;

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [FILL_W-1:0]     r_fill;
    logic [FILL_W-1:0]     w_fill_nxt;
    logic                  w_load;
    logic                  w_step;
    logic                  w_err_ev;
    logic [ERR_CODE_W-1:0] w_err_type;

    logic [WIDTH-1:0]      r_bin_cnt;
    logic [WIDTH-1:0]      r_gry_q;
    logic                  r_vld;
    logic                  r_step;
    logic                  r_err;
    logic [ERR_CODE_W-1:0] r_err_code;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    // Multi-flop synchronizer; gry_in may be asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gry_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_gry_s = r_sync[SYNC_STAGES-1];

    gry2bin #(.WIDTH(WIDTH)) u_gry2bin (
        .i_gry   (w_gry_s),
        .o_bin_c (w_bin_s)
    );

    assign w_diff    = w_gry_s ^ r_gry_q;
    assign w_one_bit = (w_diff != '0) && ((w_diff & WIDTH'(w_diff - 1'b1)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    // Fill phase waits out the synchronizer, then one unchecked load sets the baseline
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_err_ev    = 1'b0;
        w_err_type  = ERR_NONE;
        case (r_state)
            ST_FILL: begin
                if (r_fill == FILL_W'(SYNC_STAGES)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fill_nxt = FILL_W'(r_fill + 1'b1);
                end
            end
            ST_RUN: begin
                w_load = 1'b1;
                if (w_diff != '0) begin
                    if (w_one_bit && (w_bin_s == WIDTH'(r_bin_cnt + 1'b1))) begin
                        w_step = 1'b1;
                    end else if (w_one_bit && (w_bin_s == WIDTH'(r_bin_cnt - 1'b1))) begin
                        w_err_ev   = 1'b1;
                        w_err_type = ERR_BACK;
                    end else begin
                        w_err_ev   = 1'b1;
                        w_err_type = ERR_MULTI;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_cnt <= '0;
            r_gry_q   <= '0;
            r_vld     <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_vld  <= (w_state_nxt == ST_RUN);
            r_step <= w_step;
            if (w_load) begin
                r_bin_cnt <= w_bin_s;
                r_gry_q   <= w_gry_s;
            end
        end
    end

    // A new error outranks a simultaneous clear and restarts the count at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_cnt  <= '0;
        end else if (w_err_ev) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_type;
            if (err_clr) begin
                r_err_cnt <= ERR_CNT_W'(1);
            end else if (r_err_cnt != ERR_CNT_MAX) begin
                r_err_cnt <= ERR_CNT_W'(r_err_cnt + 1'b1);
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_cnt  <= '0;
        end
    end

    assign bin_cnt  = r_bin_cnt;
    assign gry_q    = r_gry_q;
    assign vld      = r_vld;
    assign step     = r_step;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_cnt_rx.sv
// Directed bench for gray_cnt_rx (WIDTH=4, SYNC_STAGES=2) with hand-computed expectations.
module tb_gray_cnt_rx;

    logic       clk;
    logic       rst_n;
    logic [3:0] gry_in;
    logic       err_clr;
    logic [3:0] bin_cnt;
    logic [3:0] gry_q;
    logic       vld;
    logic       step;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int n_vec;
    int n_bad;
    int n_steps;

    gray_cnt_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gry_in   (gry_in),
        .err_clr  (err_clr),
        .bin_cnt  (bin_cnt),
        .gry_q    (gry_q),
        .vld      (vld),
        .step     (step),
        .err      (err),
        .err_code (err_code),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".vld"},      32'(vld),      32'd0);
        chk({tag, ".bin_cnt"},  32'(bin_cnt),  32'd0);
        chk({tag, ".gry_q"},    32'(gry_q),    32'd0);
        chk({tag, ".step"},     32'(step),     32'd0);
        chk({tag, ".err"},      32'(err),      32'd0);
        chk({tag, ".err_code"}, 32'(err_code), 32'd0);
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'd0);
    endtask

    // Gray sequence 1..15 then wrap to 0
    logic [3:0] gray_seq [16];
    logic [3:0] bin_seq  [16];

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_steps = 0;
        gray_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                     4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        bin_seq  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                     4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

        // Reset with gry_in held at 0110
        rst_n   = 1'b0;
        gry_in  = 4'b0110;
        err_clr = 1'b0;
        ticks(3);
        chk_all_zero("reset");

        rst_n = 1'b1;
        tick();
        chk("prime.e1.vld", 32'(vld), 32'd0);
        tick();
        chk("prime.e2.vld", 32'(vld), 32'd0);
        tick();
        chk("prime.e3.vld",     32'(vld),     32'd1);
        chk("prime.e3.bin_cnt", 32'(bin_cnt), 32'h4);
        chk("prime.e3.gry_q",   32'(gry_q),   32'h6);
        chk("prime.e3.step",    32'(step),    32'd0);
        chk("prime.e3.err",     32'(err),     32'd0);

        // Re-prime at 0000 for the full forward sequence
        rst_n  = 1'b0;
        gry_in = 4'b0000;
        #1;
        chk_all_zero("rst2");
        tick();
        rst_n = 1'b1;
        ticks(3);
        chk("base0.vld",     32'(vld),     32'd1);
        chk("base0.bin_cnt", 32'(bin_cnt), 32'h0);

        // One change per cycle; each step lands three edges after its change
        for (int j = 0; j < 18; j++) begin
            if (j < 16) gry_in = gray_seq[j];
            tick();
            if (step === 1'b1) n_steps++;
            if (j >= 2) begin
                chk("seq.step",    32'(step),    32'd1);
                chk("seq.bin_cnt", 32'(bin_cnt), 32'(bin_seq[j-2]));
                chk("seq.gry_q",   32'(gry_q),   32'(gray_seq[j-2]));
            end else begin
                chk("seq.step_early", 32'(step), 32'd0);
            end
            chk("seq.err", 32'(err), 32'd0);
        end
        chk("seq.n_steps", 32'(n_steps), 32'd16);
        tick();
        chk("seq.step_after", 32'(step), 32'd0);

        // Multi-bit change 0001 -> 0010
        gry_in = 4'b0001;
        ticks(4);
        chk("multi.pre_bin", 32'(bin_cnt), 32'h1);
        gry_in = 4'b0010;
        ticks(2);
        chk("multi.lat_err", 32'(err), 32'd0);
        tick();
        chk("multi.err",      32'(err),      32'd1);
        chk("multi.err_code", 32'(err_code), 32'h1);
        chk("multi.err_cnt",  32'(err_cnt),  32'd1);
        chk("multi.bin_cnt",  32'(bin_cnt),  32'h3);
        chk("multi.step",     32'(step),     32'd0);

        // Backward 0010 (3) -> 0011 (2), then 0011 (2) -> 0001 (1)
        gry_in = 4'b0011;
        ticks(3);
        chk("back1.err_code", 32'(err_code), 32'h2);
        chk("back1.err_cnt",  32'(err_cnt),  32'd2);
        chk("back1.bin_cnt",  32'(bin_cnt),  32'h2);
        chk("back1.step",     32'(step),     32'd0);
        gry_in = 4'b0001;
        ticks(3);
        chk("back2.err_code", 32'(err_code), 32'h2);
        chk("back2.err_cnt",  32'(err_cnt),  32'd3);
        chk("back2.bin_cnt",  32'(bin_cnt),  32'h1);

        // 300 further illegal changes saturate the count
        for (int k = 0; k < 300; k++) begin
            gry_in = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            tick();
        end
        ticks(3);
        chk("sat.err_cnt",  32'(err_cnt),  32'd255);
        chk("sat.err",      32'(err),      32'd1);
        chk("sat.err_code", 32'(err_code), 32'h1);

        // Plain clear
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr.err",      32'(err),      32'd0);
        chk("clr.err_code", 32'(err_code), 32'd0);
        chk("clr.err_cnt",  32'(err_cnt),  32'd0);

        // Clear coincident with a multi-bit error: error wins
        gry_in = 4'b0010;
        ticks(2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clrerr.err",      32'(err),      32'd1);
        chk("clrerr.err_code", 32'(err_code), 32'h1);
        chk("clrerr.err_cnt",  32'(err_cnt),  32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clrerr.cleared", 32'(err), 32'd0);

        // One-cycle reset mid-operation, then resume at 0010
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.e1.vld", 32'(vld), 32'd0);
        tick();
        chk("midrst.e2.vld", 32'(vld), 32'd0);
        tick();
        chk("midrst.e3.vld",     32'(vld),     32'd1);
        chk("midrst.e3.bin_cnt", 32'(bin_cnt), 32'h3);
        chk("midrst.e3.err",     32'(err),     32'd0);
        gry_in = 4'b0110;
        ticks(3);
        chk("resume.step",    32'(step),    32'd1);
        chk("resume.bin_cnt", 32'(bin_cnt), 32'h4);
        chk("resume.err",     32'(err),     32'd0);
        chk("resume.err_cnt", 32'(err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_cnt_rx.md
# gray_cnt_rx

Receive-side companion to the team's Gray-code counter: samples a Gray-coded count arriving from another source, synchronizes it, decodes it to binary and checks that every observed change is a legal single step forward. Used wherever a Gray pointer or event counter crosses into this clock, for example FIFO read/write pointers or remote event counts. Emits a one-cycle pulse per legal increment and flags illegal transitions with a sticky error, an error code and a saturating error count.

## Interface
- `WIDTH`, default 4: width of the Gray count and of the decoded binary value (≥2).
- `SYNC_STAGES`, default 2: number of synchronizer flops on `gry_in` (≥2).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gry_in`  in  WIDTH  Gray-coded count; may be asynchronous to `clk`.
- `err_clr`  in  1  synchronous clear of `err`, `err_code` and `err_cnt`.
- `bin_cnt`  out  WIDTH  registered binary decode of the synchronized count.
- `gry_q`  out  WIDTH  registered synchronized Gray value, aligned with `bin_cnt`.
- `vld`  out  1  high once a baseline sample has been taken after reset.
- `step`  out  1  one-cycle pulse: the count advanced by exactly +1 (mod 2^WIDTH).
- `err`  out  1  sticky flag: an illegal transition was seen.
- `err_code`  out  2  type of the most recent error: 01 = multi-bit change, 10 = backward step.
- `err_cnt`  out  8  count of illegal transitions, saturating at 255.

## Operation
- Synchronizer: `gry_in` passes through `SYNC_STAGES` flops; the last stage is `gry_s`.
- Decode: `bin_s[WIDTH-1] = gry_s[WIDTH-1]`; `bin_s[i] = bin_s[i+1] ^ gry_s[i]`.
- Priming: a fill counter runs for `SYNC_STAGES` cycles after reset release. On the next cycle, `gry_q`/`bin_cnt` load `gry_s`/`bin_s` with no check, and `vld` rises and stays high.
- Each cycle with `vld` = 1, compare `gry_s` with `gry_q`:
  - Hamming distance 0: no event.
  - Distance 1 and `bin_s == bin_cnt+1` (mod 2^WIDTH): `step` = 1.
  - Distance 1 and `bin_s == bin_cnt-1`: error, code 10.
  - Distance >1: error, code 01.
- In every case with `vld` = 1, `gry_q`/`bin_cnt` load the new value, so the decoder resynchronizes to the observed value.
- On an error: `err` ← 1, `err_code` ← type, `err_cnt` ← `err_cnt+1`, holding at 255.
- `err_clr` clears `err`, `err_code` and `err_cnt` to 0. If an error occurs in the same cycle as `err_clr`, the error wins: `err` = 1, `err_code` = type, `err_cnt` = 1.
- Wrap-around: `gry_q` = 1000 (bin 15) to `gry_s` = 0000 (bin 0), WIDTH=4, is a legal `step`.
- `step` and an error never assert in the same cycle.

## Timing
- Reset values: all outputs 0; synchronizer flops 0; fill counter 0.
- Reset asserted mid-operation: everything returns to reset values immediately, and priming restarts after release.
- Latency from a `gry_in` change to the `bin_cnt`/`gry_q`/`step`/`err` update is `SYNC_STAGES`+1 rising edges. `step` and the error updates land on the same edge as `bin_cnt`.
- `vld` rises `SYNC_STAGES`+1 edges after the first edge with `rst_n` high.
- The source must change at most once per `clk` cycle. Faster sources are detected as multi-bit errors.

## Structure
- Package `gray_pkg`: `ERR_NONE`=2'b00, `ERR_MULTI`=2'b01, `ERR_BACK`=2'b10, and `ERR_CNT_MAX`=8'd255.
- Sub-module `gry2bin`, parameterized by `WIDTH`: purely combinational Gray-to-binary decode.
- The synchronizer, fill counter, checker and error registers stay in `gray_cnt_rx`.

## Test plan
- Reset release with `gry_in` held at 0110 (WIDTH=4, SYNC_STAGES=2) -> `vld` rises at edge 3, `bin_cnt`=0100, no `step`, `err`=0.
- Drive the Gray sequence 0000→0001→0011→…→1000→0000, one change per cycle -> 16 `step` pulses each 3 edges after their change, `bin_cnt` 0..15 then 0, `err`=0.
- After `vld`, drive `gry_in` from 0001 to 0010 -> `err`=1, `err_code`=01, `err_cnt`=1, `bin_cnt`=0011, no `step`.
- After `vld`, drive `gry_in` from 0011 back to 0001 -> `err_code`=10, `err_cnt` increments; repeat 300 illegal changes -> `err_cnt` holds at 255.
- Assert `err_clr` in the same cycle a multi-bit error is detected -> `err`=1, `err_cnt`=1.
- Assert `rst_n` low mid-sequence for one cycle -> all outputs 0, `vld` low for `SYNC_STAGES`+1 edges, then resume with no spurious `err`.
